// File: rtl/matrix_buffer_rc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_pkg
//  Description : Shared constants, scan state encoding and the linear-index
//                helper for the matrix buffer with row/column scan.
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_pkg;

  // Default geometry: a 3x3 matrix of 3-bit elements
  localparam int DEF_DATA_W = 3;
  localparam int DEF_ROWS   = 3;
  localparam int DEF_COLS   = 3;

  // Scan engine states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  // Scan order, as seen on scan_col_major
  localparam logic ROW_MAJOR = 1'b0;
  localparam logic COL_MAJOR = 1'b1;

  // Storage is flat and row-major: entry(row, col) lives at row*cols + col
  function automatic int unsigned lin_idx(input int unsigned row,
                                          input int unsigned col,
                                          input int unsigned cols);
    return row * cols + col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_buffer_rc_if.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_buffer_rc_if
//  Description : Valid/ready stream carrying scanned matrix elements with
//                their row/column coordinates and an end-of-scan marker.
//  Revision    : 1.0 - initial release
// ============================================================================
interface matrix_buffer_rc_if #(
  parameter int DATA_W = 3,
  parameter int ROW_W  = 2,
  parameter int COL_W  = 2
);

  logic              scan_valid;
  logic              scan_ready;
  logic [DATA_W-1:0] scan_data;
  logic [ROW_W-1:0]  scan_row;
  logic [COL_W-1:0]  scan_col;
  logic              scan_last;

  // Producer side (the matrix buffer)
  modport master (
    output scan_valid,
    output scan_data,
    output scan_row,
    output scan_col,
    output scan_last,
    input  scan_ready
  );

  // Consumer side (e.g. the multiplier FSM)
  modport slave (
    input  scan_valid,
    input  scan_data,
    input  scan_row,
    input  scan_col,
    input  scan_last,
    output scan_ready
  );

endinterface
`default_nettype wire

// File: rtl/matrix_buffer_rc_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_scan_ctrl
//  Description : Scan sequencer. Walks every (row, col) of the matrix once in
//                row-major or column-major order, pacing on the consumer's
//                ready, and tells the storage which element to load next.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int ROW_W = 2,
  parameter int COL_W = 2
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              start,
  input  wire              col_major,
  input  wire              ready,
  output logic             load,
  output logic [ROW_W-1:0] ld_row,
  output logic [COL_W-1:0] ld_col,
  output logic             ld_last,
  output logic             busy
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  scan_state_e      state_q, state_d;
  logic             order_q, order_d;
  logic [ROW_W-1:0] cur_row_q, cur_row_d;
  logic [COL_W-1:0] cur_col_q, cur_col_d;

  logic [ROW_W-1:0] nxt_row;
  logic [COL_W-1:0] nxt_col;
  logic             cur_last;

  // Successor of the presented element in the latched order
  always_comb begin
    nxt_row = cur_row_q;
    nxt_col = cur_col_q;
    if (order_q == COL_MAJOR) begin
      if (cur_row_q == ROW_LAST) begin
        nxt_row = '0;
        nxt_col = cur_col_q + COL_W'(1);
      end else begin
        nxt_row = cur_row_q + ROW_W'(1);
      end
    end else begin
      if (cur_col_q == COL_LAST) begin
        nxt_col = '0;
        nxt_row = cur_row_q + ROW_W'(1);
      end else begin
        nxt_col = cur_col_q + COL_W'(1);
      end
    end
  end

  assign cur_last = (cur_row_q == ROW_LAST) && (cur_col_q == COL_LAST);

  // Next-state, load strobe and load index
  always_comb begin
    state_d   = state_q;
    order_d   = order_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    load      = 1'b0;
    ld_row    = cur_row_q;
    ld_col    = cur_col_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          order_d = col_major;
          load    = 1'b1;
          ld_row  = '0;
          ld_col  = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // start is deliberately not looked at here, even on the final handshake
        if (ready) begin
          if (cur_last) begin
            state_d = IDLE;
          end else begin
            load   = 1'b1;
            ld_row = nxt_row;
            ld_col = nxt_col;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      cur_row_d = ld_row;
      cur_col_d = ld_col;
    end
  end

  assign ld_last = (ld_row == ROW_LAST) && (ld_col == COL_LAST);
  assign busy    = (state_q == SCAN);

  // State and position registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      order_q   <= ROW_MAJOR;
      cur_row_q <= '0;
      cur_col_q <= '0;
    end else begin
      state_q   <= state_d;
      order_q   <= order_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/matrix_buffer_rc.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_buffer_rc
//  Description : Writable ROWS x COLS matrix store with a registered random
//                read port and a handshaked full-matrix scan stream in
//                row-major or column-major order.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_buffer_rc
  import matrix_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int ROW_W  = 2,
  parameter int COL_W  = 2
) (
  input  wire               clk,
  input  wire               rst,
  input  wire               wr_en,
  input  wire  [ROW_W-1:0]  wr_row,
  input  wire  [COL_W-1:0]  wr_col,
  input  wire  [DATA_W-1:0] wr_data,
  input  wire  [ROW_W-1:0]  rd_row,
  input  wire  [COL_W-1:0]  rd_col,
  output logic [DATA_W-1:0] rd_data,
  input  wire               scan_start,
  input  wire               scan_col_major,
  output logic              busy,
  matrix_buffer_rc_if.master scan
);

  localparam int DEPTH = ROWS * COLS;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] scan_data_q, scan_data_d;
  logic [ROW_W-1:0]  scan_row_q, scan_row_d;
  logic [COL_W-1:0]  scan_col_q, scan_col_d;
  logic              scan_last_q, scan_last_d;

  logic              ld;
  logic [ROW_W-1:0]  ld_row;
  logic [COL_W-1:0]  ld_col;
  logic              ld_last;
  logic              scan_busy;

  matrix_scan_ctrl #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_scan_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start     (scan_start),
    .col_major (scan_col_major),
    .ready     (scan.scan_ready),
    .load      (ld),
    .ld_row    (ld_row),
    .ld_col    (ld_col),
    .ld_last   (ld_last),
    .busy      (scan_busy)
  );

  // Write port: matching against every legal coordinate drops out-of-range writes
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (wr_row == ROW_W'(r) && wr_col == COL_W'(c)) begin
            mem_d[lin_idx(r, c, COLS)] = wr_data;
          end
        end
      end
    end
  end

  // Random read of the pre-write contents; an unmatched index reads as 0
  always_comb begin
    rd_data_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (rd_row == ROW_W'(r) && rd_col == COL_W'(c)) begin
          rd_data_d = mem_q[lin_idx(r, c, COLS)];
        end
      end
    end
  end

  // Scan output register: snapshot the selected element on a load, else hold
  always_comb begin
    scan_data_d = scan_data_q;
    scan_row_d  = scan_row_q;
    scan_col_d  = scan_col_q;
    scan_last_d = scan_last_q;
    if (ld) begin
      scan_data_d = '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (ld_row == ROW_W'(r) && ld_col == COL_W'(c)) begin
            scan_data_d = mem_q[lin_idx(r, c, COLS)];
          end
        end
      end
      scan_row_d  = ld_row;
      scan_col_d  = ld_col;
      scan_last_d = ld_last;
    end
  end

  // Storage, read and scan output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q   <= '0;
      scan_data_q <= '0;
      scan_row_q  <= '0;
      scan_col_q  <= '0;
      scan_last_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_data_q   <= rd_data_d;
      scan_data_q <= scan_data_d;
      scan_row_q  <= scan_row_d;
      scan_col_q  <= scan_col_d;
      scan_last_q <= scan_last_d;
    end
  end

  assign rd_data         = rd_data_q;
  assign busy            = scan_busy;
  assign scan.scan_valid = scan_busy;
  assign scan.scan_data  = scan_data_q;
  assign scan.scan_row   = scan_row_q;
  assign scan.scan_col   = scan_col_q;
  assign scan.scan_last  = scan_last_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_buffer_rc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_buffer_rc
//  Description : Self-checking bench for matrix_buffer_rc (3x3 and 1x1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_buffer_rc;

  localparam int DW = 3;
  localparam int R  = 3;
  localparam int C  = 3;
  localparam int RW = 2;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wr_en, scan_start, scan_col_major, busy;
  logic [RW-1:0] wr_row, rd_row;
  logic [CW-1:0] wr_col, rd_col;
  logic [DW-1:0] wr_data, rd_data;

  matrix_buffer_rc_if #(.DATA_W(DW), .ROW_W(RW), .COL_W(CW)) sif ();

  matrix_buffer_rc #(.DATA_W(DW), .ROWS(R), .COLS(C), .ROW_W(RW), .COL_W(CW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .scan_start(scan_start), .scan_col_major(scan_col_major), .busy(busy),
    .scan(sif)
  );

  // 1x1 instance
  logic          wr1_en, st1, cm1, busy1;
  logic [0:0]    wr1_row, wr1_col, rd1_row, rd1_col;
  logic [DW-1:0] wr1_data, rd1_data;

  matrix_buffer_rc_if #(.DATA_W(DW), .ROW_W(1), .COL_W(1)) sif1 ();

  matrix_buffer_rc #(.DATA_W(DW), .ROWS(1), .COLS(1), .ROW_W(1), .COL_W(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr1_en), .wr_row(wr1_row), .wr_col(wr1_col),
    .wr_data(wr1_data), .rd_row(rd1_row), .rd_col(rd1_col), .rd_data(rd1_data),
    .scan_start(st1), .scan_col_major(cm1), .busy(busy1),
    .scan(sif1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: matrix contents plus the element the scan is presenting
  int mem_m [R*C];
  int rd_m, k_m, sd_m, sr_m, sc_m;
  bit v_m, cm_m, sl_m, rz_m;

  function automatic void load_elem();
    int r, c;
    if (!cm_m) begin r = k_m / C; c = k_m % C; end
    else       begin c = k_m / R; r = k_m % R; end
    sd_m = mem_m[r*C + c];
    sr_m = r;
    sc_m = c;
    sl_m = (k_m == R*C - 1);
    rz_m = 1'b0;
  endfunction

  function automatic void model_edge();
    int new_rd;
    if (rst) begin
      foreach (mem_m[i]) mem_m[i] = 0;
      rd_m = 0; v_m = 0; sd_m = 0; sr_m = 0; sc_m = 0; sl_m = 0; rz_m = 1;
      return;
    end
    new_rd = (int'(rd_row) < R && int'(rd_col) < C) ? mem_m[int'(rd_row)*C + int'(rd_col)] : 0;
    if (!v_m) begin
      if (scan_start) begin
        cm_m = scan_col_major; k_m = 0; load_elem(); v_m = 1;
      end
    end else if (sif.scan_ready) begin
      if (k_m == R*C - 1) v_m = 0;
      else begin k_m++; load_elem(); end
    end
    if (wr_en && int'(wr_row) < R && int'(wr_col) < C)
      mem_m[int'(wr_row)*C + int'(wr_col)] = int'(wr_data);
    rd_m = new_rd;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_value("rd_data", rd_data, rd_m);
    check_value("scan_valid", sif.scan_valid, v_m);
    check_value("busy", busy, v_m);
    if (v_m || rz_m) begin
      check_value("scan_data", sif.scan_data, sd_m);
      check_value("scan_row", sif.scan_row, sr_m);
      check_value("scan_col", sif.scan_col, sc_m);
      check_value("scan_last", sif.scan_last, sl_m);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst = 1; wr_en = 0; wr_row = 0; wr_col = 0; wr_data = 0; rd_row = 0; rd_col = 0;
    scan_start = 0; scan_col_major = 0; sif.scan_ready = 1;
    wr1_en = 0; wr1_row = 0; wr1_col = 0; wr1_data = 0; rd1_row = 0; rd1_col = 0;
    st1 = 0; cm1 = 0; sif1.scan_ready = 1;

    step(); step();
    rst = 0; rd_row = 1; rd_col = 2;
    step();
    check_value("rst_rd_data", rd_data, 0);
    check_value("rst_scan_valid", sif.scan_valid, 0);
    check_value("rst_1x1_valid", sif1.scan_valid, 0);

    // Write (1,2)=5 while reading it: old value first, new one a cycle later
    wr_en = 1; wr_row = 1; wr_col = 2; wr_data = 5;
    step();
    check_value("rd_same_cycle_old", rd_data, 0);
    wr_en = 0;
    step();
    check_value("rd_latency1", rd_data, 5);

    // Every row holds 1,2,3
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        wr_en = 1; wr_row = RW'(r); wr_col = CW'(c); wr_data = DW'(c + 1);
        step();
      end
    wr_en = 0;

    // Row-major scan
    scan_col_major = 0; scan_start = 1;
    step();
    scan_start = 0;
    for (int i = 0; i < R*C; i++) begin
      check_value("rm_data", sif.scan_data, i % 3 + 1);
      check_value("rm_row", sif.scan_row, i / 3);
      check_value("rm_col", sif.scan_col, i % 3);
      check_value("rm_last", sif.scan_last, (i == R*C - 1));
      step();
    end
    check_value("rm_busy_drop", busy, 0);

    // Column-major scan
    scan_col_major = 1; scan_start = 1;
    step();
    scan_start = 0; scan_col_major = 0;
    for (int i = 0; i < R*C; i++) begin
      check_value("cm_data", sif.scan_data, i / 3 + 1);
      check_value("cm_row", sif.scan_row, i % 3);
      check_value("cm_col", sif.scan_col, i / 3);
      check_value("cm_last", sif.scan_last, (i == R*C - 1));
      step();
    end
    check_value("cm_busy_drop", busy, 0);

    // Back-pressure on element (0,1) with scan_start pulsed mid-scan
    scan_start = 1;
    step();
    scan_start = 0;
    step();
    sif.scan_ready = 0; scan_start = 1;
    repeat (3) begin
      step();
      check_value("stall_data", sif.scan_data, 2);
      check_value("stall_col", sif.scan_col, 1);
      check_value("stall_valid", sif.scan_valid, 1);
    end
    sif.scan_ready = 1;
    step();
    check_value("stall_resume", sif.scan_data, 3);
    // scan_start stays high through the final handshake, which must ignore it
    cnt = 0;
    while (sif.scan_valid && cnt < 20) begin step(); cnt++; end
    scan_start = 0;
    check_value("drain_in_time", (cnt < 20), 1);
    step();
    check_value("final_start_ignored", sif.scan_valid, 0);

    // Out-of-range write and read
    wr_en = 1; wr_row = 3; wr_col = 0; wr_data = 7; rd_row = 0; rd_col = 3;
    step();
    wr_en = 0;
    check_value("rd_oob", rd_data, 0);
    rd_row = 0; rd_col = 0;
    step();
    check_value("oob_write_ignored", rd_data, 1);

    // Reset while the 4th element is presented
    scan_start = 1;
    step();
    scan_start = 0;
    repeat (3) step();
    check_value("pre_rst_row", sif.scan_row, 1);
    rst = 1;
    step();
    rst = 0;
    check_value("midscan_rst_valid", sif.scan_valid, 0);
    check_value("midscan_rst_busy", busy, 0);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        rd_row = RW'(r); rd_col = CW'(c);
        step();
        check_value("cleared", rd_data, 0);
      end
    check_value("no_emit_after_rst", sif.scan_valid, 0);

    // 1x1 matrix: single element, last on the first
    wr1_en = 1; wr1_row = 0; wr1_col = 0; wr1_data = 6;
    step();
    wr1_row = 1; wr1_data = 3;
    step();
    wr1_en = 0; wr1_row = 0;
    step();
    check_value("m1_rd", rd1_data, 6);
    st1 = 1;
    step();
    st1 = 0;
    check_value("m1_valid", sif1.scan_valid, 1);
    check_value("m1_last", sif1.scan_last, 1);
    check_value("m1_data", sif1.scan_data, 6);
    step();
    check_value("m1_done", sif1.scan_valid, 0);
    check_value("m1_busy", busy1, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      rst            = ($urandom_range(0, 63) == 0);
      wr_en          = $urandom_range(0, 1);
      wr_row         = RW'($urandom_range(0, 3));
      wr_col         = CW'($urandom_range(0, 3));
      wr_data        = DW'($urandom_range(0, 7));
      rd_row         = RW'($urandom_range(0, 3));
      rd_col         = CW'($urandom_range(0, 3));
      scan_start     = ($urandom_range(0, 3) == 0);
      scan_col_major = $urandom_range(0, 1);
      sif.scan_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_buffer_rc.md
Name: matrix_buffer_rc

Overview:
Parametrised successor to the fixed 3x3 matrix ROM: a writable ROWS x COLS matrix store with a registered random-access read port. Adds a handshaked streaming scan engine that emits the whole matrix in row-major or column-major (transposed) order. Feeds the multiplier FSM as either operand; column-major scan supplies the B-operand columns directly.

Parameters:
DATA_W, 3, element width in bits
ROWS, 3, matrix rows (>=1)
COLS, 3, matrix columns (>=1)
ROW_W, 2, row index width, must satisfy 2**ROW_W >= ROWS
COL_W, 2, column index width, must satisfy 2**COL_W >= COLS

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
wr_en  in  1  write strobe
wr_row  in  ROW_W  write row index
wr_col  in  COL_W  write column index
wr_data  in  DATA_W  write data
rd_row  in  ROW_W  random-read row index
rd_col  in  COL_W  random-read column index
rd_data  out  DATA_W  registered random-read data
scan_start  in  1  start a full-matrix scan, sampled only when idle
scan_col_major  in  1  scan order, latched with scan_start: 0 row-major, 1 column-major
scan_valid  out  1  scan_data/scan_row/scan_col/scan_last hold a valid element
scan_ready  in  1  consumer accepts the element this cycle
scan_data  out  DATA_W  scanned element
scan_row  out  ROW_W  row index of scan_data
scan_col  out  COL_W  column index of scan_data
scan_last  out  1  scan_data is the final element of the scan
busy  out  1  scan in progress (state SCAN)

Behaviour:
- Reset (rst=1 at an edge): all ROWS*COLS entries cleared to 0, rd_data=0, scan_valid=0, scan_data=0, scan_row=0, scan_col=0, scan_last=0, busy=0, FSM returns to IDLE. Reset wins over every other input. Reset mid-scan aborts the scan; no element is emitted afterwards.
- Storage: linear index = row*COLS + col.
- Write: when wr_en=1 and (wr_row<ROWS, wr_col<COLS), the entry is updated at the edge. Out-of-range writes are ignored.
- Random read: rd_data <= entry(rd_row, rd_col) every edge, so latency is 1 cycle with no enable. Out-of-range index gives 0. A read and write to the same address in the same cycle returns the old value.
- FSM states:
  - IDLE: busy=0, scan_valid=0. If scan_start=1, the edge latches scan_col_major, loads element (0,0) into the scan output registers, sets scan_valid=1 and moves to SCAN.
  - SCAN: busy=1, scan_valid=1.
    - valid&&!ready: all scan outputs hold stable.
    - valid&&ready, not last: the next element in the selected order loads at that edge.
    - valid&&ready with scan_last=1: FSM goes to IDLE and scan_valid=0 next cycle.
- Order:
  - Row-major: col increments, wrapping to 0 and incrementing row at COLS-1.
  - Column-major: row increments, wrapping to 0 and incrementing col at ROWS-1.
- scan_last=1 exactly when the element loaded is (ROWS-1, COLS-1).
- The scan output register samples memory at load time. A write to the address being loaded on the same edge yields the old value. A write to an element already loaded does not change the held output.
- scan_start while busy, including the cycle of the final handshake, is ignored. Minimum gap between scans is one IDLE cycle.
- A 1x1 matrix gives a single element with scan_last=1.

Decomposition:
- Package matrix_pkg: default DATA_W/ROWS/COLS constants, scan state enum (IDLE, SCAN), scan-order constants (ROW_MAJOR=0, COL_MAJOR=1), linear-index function.
- Sub-module matrix_scan_ctrl: FSM plus row/col counters with order-dependent wrap. Outputs the next index, load strobe, last flag and busy.
- Top level owns the storage array, the write and read ports, and the scan output registers.

Test Plan:
- Reset, then rd_row=1, rd_col=2: rd_data=0 one cycle later. Write (1,2)=5, then read (1,2): 5 appears exactly 1 cycle after the address is presented.
- Load rows 1,2,3 / 1,2,3 / 1,2,3; scan_start with col_major=0 and ready=1: scan_data 1,2,3,1,2,3,1,2,3 on consecutive cycles, scan_last only on the 9th, busy drops the cycle after.
- Same data, col_major=1: scan_data 1,1,1,2,2,2,3,3,3 with scan_row 0,1,2 cycling and scan_col stepping 0,1,2.
- Row-major scan with ready=0 for 3 cycles while presenting element 2 (value 2, row 0, col 1): outputs held for those 3 cycles, resuming with 3 on the cycle after ready returns high. scan_start pulsed mid-scan: ignored.
- Write to (3,0) and read (0,3) at the 3x3 default: write ignored, rd_data=0. rst asserted while the 4th element is valid: scan_valid=0, busy=0 next cycle, all entries read 0.
